// File: rtl/fis_param_store.sv
// Parameter store: parses framed host packets into five register files, serves 1-cycle registered read ports.
// Host stream stalls (s_ready low) only while lock is high or reset is asserted; read ports never stall.
module fis_param_store #(
    parameter int IN_DEPTH    = 3,
    parameter int INMF_DEPTH  = 45,
    parameter int OUTMF_DEPTH = 21,
    parameter int RULE_DEPTH  = 36
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        lock,
    input  logic        clear,
    output logic [4:0]  load_mask,
    output logic        params_ready,
    output logic        load_err,
    input  logic [3:0]  input_data_i_address0,
    input  logic        input_data_i_ce0,
    output logic [31:0] input_data_i_q0,
    input  logic [3:0]  input_nums_address0,
    input  logic        input_nums_ce0,
    output logic [11:0] input_nums_q0,
    input  logic [7:0]  inMF_i_address0,
    input  logic        inMF_i_ce0,
    output logic [31:0] inMF_i_q0,
    input  logic [4:0]  outMF_i_address0,
    input  logic        outMF_i_ce0,
    output logic [31:0] outMF_i_q0,
    input  logic [14:0] rule_i_address0,
    input  logic        rule_i_ce0,
    output logic [5:0]  rule_i_q0
);

    localparam int IN_AW    = (IN_DEPTH    > 1) ? $clog2(IN_DEPTH)    : 1;
    localparam int INMF_AW  = (INMF_DEPTH  > 1) ? $clog2(INMF_DEPTH)  : 1;
    localparam int OUTMF_AW = (OUTMF_DEPTH > 1) ? $clog2(OUTMF_DEPTH) : 1;
    localparam int RULE_AW  = (RULE_DEPTH  > 1) ? $clog2(RULE_DEPTH)  : 1;

    localparam logic [15:0] IN_D16    = 16'(IN_DEPTH);
    localparam logic [15:0] INMF_D16  = 16'(INMF_DEPTH);
    localparam logic [15:0] OUTMF_D16 = 16'(OUTMF_DEPTH);
    localparam logic [15:0] RULE_D16  = 16'(RULE_DEPTH);

    localparam logic [3:0]  IN_ALIM    = 4'(IN_DEPTH);
    localparam logic [7:0]  INMF_ALIM  = 8'(INMF_DEPTH);
    localparam logic [4:0]  OUTMF_ALIM = 5'(OUTMF_DEPTH);
    localparam logic [14:0] RULE_ALIM  = 15'(RULE_DEPTH);

    typedef enum logic [0:0] {ST_HDR = 1'b0, ST_PAY = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [2:0]  region_q, region_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  mask_q, mask_d;
    logic        err_q, err_d;

    logic [31:0] in_mem_q   [IN_DEPTH];
    logic [31:0] inmf_mem_q [INMF_DEPTH];
    logic [31:0] outmf_mem_q[OUTMF_DEPTH];
    logic [5:0]  rule_mem_q [RULE_DEPTH];
    logic [11:0] nums_q;

    logic [31:0] in_q0_q, in_q0_d;
    logic [31:0] inmf_q0_q, inmf_q0_d;
    logic [31:0] outmf_q0_q, outmf_q0_d;
    logic [5:0]  rule_q0_q, rule_q0_d;
    logic [11:0] nums_q0_q, nums_q0_d;

    logic        xfer;
    logic [3:0]  hdr_region;
    logic [15:0] hdr_len;
    logic        hdr_bad;
    logic [15:0] depth16;
    logic        in_range;
    logic        last_word;
    logic        wr_en, wr_in, wr_inmf, wr_outmf, wr_rule, wr_nums;
    logic        unused_nums_addr;

    assign unused_nums_addr = ^input_nums_address0;

    assign s_ready    = ap_rst_n & ~lock;
    assign xfer       = s_valid & ap_rst_n & ~lock;
    assign hdr_region = s_data[31:28];
    assign hdr_len    = s_data[15:0];
    assign hdr_bad    = (hdr_len == 16'd0) || (hdr_region > 4'd4);
    assign in_range   = cnt_q < depth16;
    assign last_word  = cnt_q == (len_q - 16'd1);

    always_comb begin
        depth16 = 16'd0;
        case (region_q)
            3'd0:    depth16 = IN_D16;
            3'd1:    depth16 = INMF_D16;
            3'd2:    depth16 = OUTMF_D16;
            3'd3:    depth16 = RULE_D16;
            3'd4:    depth16 = 16'd1;
            default: depth16 = 16'd0;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q  <= ST_HDR;
            region_q <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            region_q <= region_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            err_q    <= err_d;
        end
    end

    // clear outranks any transfer in the same cycle; that word is simply lost
    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        err_d    = err_q;
        if (clear) begin
            state_d = ST_HDR;
            cnt_d   = 16'd0;
            mask_d  = 5'd0;
            err_d   = 1'b0;
        end else if (xfer) begin
            case (state_q)
                ST_HDR: begin
                    region_d = hdr_region[2:0];
                    len_d    = hdr_len;
                    cnt_d    = 16'd0;
                    if (hdr_region <= 4'd4) mask_d[hdr_region[2:0]] = 1'b0;
                    if (hdr_bad) err_d = 1'b1;
                    else         state_d = ST_PAY;
                end
                ST_PAY: begin
                    if (!in_range) err_d = 1'b1;
                    cnt_d = cnt_q + 16'd1;
                    if (last_word) begin
                        state_d = ST_HDR;
                        if (len_q <= depth16) mask_d[region_q] = 1'b1;
                    end
                end
                default: state_d = ST_HDR;
            endcase
        end
    end

    always_comb begin
        wr_en    = (state_q == ST_PAY) && xfer && !clear && in_range;
        wr_in    = wr_en && (region_q == 3'd0);
        wr_inmf  = wr_en && (region_q == 3'd1);
        wr_outmf = wr_en && (region_q == 3'd2);
        wr_rule  = wr_en && (region_q == 3'd3);
        wr_nums  = wr_en && (region_q == 3'd4);
    end

    assign load_mask    = mask_q;
    assign load_err     = err_q;
    assign params_ready = (mask_q == 5'h1F);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < IN_DEPTH; i++)    in_mem_q[i]    <= '0;
            for (int i = 0; i < INMF_DEPTH; i++)  inmf_mem_q[i]  <= '0;
            for (int i = 0; i < OUTMF_DEPTH; i++) outmf_mem_q[i] <= '0;
            for (int i = 0; i < RULE_DEPTH; i++)  rule_mem_q[i]  <= '0;
            nums_q <= '0;
        end else begin
            if (wr_in)    in_mem_q[cnt_q[IN_AW-1:0]]       <= s_data;
            if (wr_inmf)  inmf_mem_q[cnt_q[INMF_AW-1:0]]   <= s_data;
            if (wr_outmf) outmf_mem_q[cnt_q[OUTMF_AW-1:0]] <= s_data;
            if (wr_rule)  rule_mem_q[cnt_q[RULE_AW-1:0]]   <= s_data[5:0];
            if (wr_nums)  nums_q                           <= s_data[11:0];
        end
    end

    // reads sample pre-write contents, so a same-address write in this cycle is not visible yet
    always_comb begin
        in_q0_d    = in_q0_q;
        inmf_q0_d  = inmf_q0_q;
        outmf_q0_d = outmf_q0_q;
        rule_q0_d  = rule_q0_q;
        nums_q0_d  = nums_q0_q;
        if (input_data_i_ce0)
            in_q0_d = (input_data_i_address0 < IN_ALIM) ?
                      in_mem_q[input_data_i_address0[IN_AW-1:0]] : 32'd0;
        if (inMF_i_ce0)
            inmf_q0_d = (inMF_i_address0 < INMF_ALIM) ?
                        inmf_mem_q[inMF_i_address0[INMF_AW-1:0]] : 32'd0;
        if (outMF_i_ce0)
            outmf_q0_d = (outMF_i_address0 < OUTMF_ALIM) ?
                         outmf_mem_q[outMF_i_address0[OUTMF_AW-1:0]] : 32'd0;
        if (rule_i_ce0)
            rule_q0_d = (rule_i_address0 < RULE_ALIM) ?
                        rule_mem_q[rule_i_address0[RULE_AW-1:0]] : 6'd0;
        if (input_nums_ce0)
            nums_q0_d = nums_q;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            in_q0_q    <= '0;
            inmf_q0_q  <= '0;
            outmf_q0_q <= '0;
            rule_q0_q  <= '0;
            nums_q0_q  <= '0;
        end else begin
            in_q0_q    <= in_q0_d;
            inmf_q0_q  <= inmf_q0_d;
            outmf_q0_q <= outmf_q0_d;
            rule_q0_q  <= rule_q0_d;
            nums_q0_q  <= nums_q0_d;
        end
    end

    assign input_data_i_q0 = in_q0_q;
    assign inMF_i_q0       = inmf_q0_q;
    assign outMF_i_q0      = outmf_q0_q;
    assign rule_i_q0       = rule_q0_q;
    assign input_nums_q0   = nums_q0_q;

endmodule

// File: tb/tb_fis_param_store.sv
// Randomized bench for fis_param_store: packet-level model plus a read-port scoreboard.
module tb_fis_param_store;

    localparam int IN_D = 3, MF_D = 45, OUT_D = 21, RU_D = 36;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        lock = 1'b0;
    logic        clear = 1'b0;
    logic [4:0]  load_mask;
    logic        params_ready;
    logic        load_err;
    logic [3:0]  input_data_i_address0 = '0;
    logic        input_data_i_ce0 = 1'b0;
    logic [31:0] input_data_i_q0;
    logic [3:0]  input_nums_address0 = '0;
    logic        input_nums_ce0 = 1'b0;
    logic [11:0] input_nums_q0;
    logic [7:0]  inMF_i_address0 = '0;
    logic        inMF_i_ce0 = 1'b0;
    logic [31:0] inMF_i_q0;
    logic [4:0]  outMF_i_address0 = '0;
    logic        outMF_i_ce0 = 1'b0;
    logic [31:0] outMF_i_q0;
    logic [14:0] rule_i_address0 = '0;
    logic        rule_i_ce0 = 1'b0;
    logic [5:0]  rule_i_q0;

    fis_param_store dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .lock(lock), .clear(clear),
        .load_mask(load_mask), .params_ready(params_ready), .load_err(load_err),
        .input_data_i_address0(input_data_i_address0), .input_data_i_ce0(input_data_i_ce0),
        .input_data_i_q0(input_data_i_q0),
        .input_nums_address0(input_nums_address0), .input_nums_ce0(input_nums_ce0),
        .input_nums_q0(input_nums_q0),
        .inMF_i_address0(inMF_i_address0), .inMF_i_ce0(inMF_i_ce0), .inMF_i_q0(inMF_i_q0),
        .outMF_i_address0(outMF_i_address0), .outMF_i_ce0(outMF_i_ce0), .outMF_i_q0(outMF_i_q0),
        .rule_i_address0(rule_i_address0), .rule_i_ce0(rule_i_ce0), .rule_i_q0(rule_i_q0)
    );

    initial forever #5 ap_clk = ~ap_clk;

    // Reference model: region contents and flags, updated per packet word
    logic [31:0] m_in  [IN_D];
    logic [31:0] m_mf  [MF_D];
    logic [31:0] m_out [OUT_D];
    logic [5:0]  m_rule[RU_D];
    logic [11:0] m_nums;
    logic [4:0]  m_mask;
    logic        m_err;
    logic [31:0] nums_word;

    logic [31:0] q_in[$], q_mf[$], q_out[$], q_rule[$], q_nums[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic miss(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: read data presented but no expected entry queued", nm);
    endtask

    function automatic int depth_of(input int r);
        case (r)
            0: return IN_D;
            1: return MF_D;
            2: return OUT_D;
            3: return RU_D;
            4: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input int r, input int a);
        if (r == 4) return {20'd0, m_nums};
        if (a >= depth_of(r)) return 32'd0;
        case (r)
            0: return m_in[a];
            1: return m_mf[a];
            2: return m_out[a];
            default: return {26'd0, m_rule[a]};
        endcase
    endfunction

    task automatic model_write(input int r, input int i, input logic [31:0] w);
        if (i >= depth_of(r)) m_err = 1'b1;
        else case (r)
            0: m_in[i] = w;
            1: m_mf[i] = w;
            2: m_out[i] = w;
            3: m_rule[i] = w[5:0];
            default: m_nums = w[11:0];
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < IN_D; i++)  m_in[i] = '0;
        for (int i = 0; i < MF_D; i++)  m_mf[i] = '0;
        for (int i = 0; i < OUT_D; i++) m_out[i] = '0;
        for (int i = 0; i < RU_D; i++)  m_rule[i] = '0;
        m_nums = '0;
        m_mask = '0;
        m_err  = 1'b0;
    endtask

    task automatic rd(input int r, input int a);
        case (r)
            0: begin input_data_i_address0 = 4'(a); input_data_i_ce0 = 1'b1; q_in.push_back(model_read(0, a)); end
            1: begin inMF_i_address0 = 8'(a); inMF_i_ce0 = 1'b1; q_mf.push_back(model_read(1, a)); end
            2: begin outMF_i_address0 = 5'(a); outMF_i_ce0 = 1'b1; q_out.push_back(model_read(2, a)); end
            3: begin rule_i_address0 = 15'(a); rule_i_ce0 = 1'b1; q_rule.push_back(model_read(3, a)); end
            default: begin input_nums_address0 = 4'(a); input_nums_ce0 = 1'b1; q_nums.push_back(model_read(4, a)); end
        endcase
    endtask

    task automatic rd_idle();
        input_data_i_ce0 = 1'b0; inMF_i_ce0 = 1'b0; outMF_i_ce0 = 1'b0;
        rule_i_ce0 = 1'b0; input_nums_ce0 = 1'b0;
    endtask

    // Back-to-back reads of a whole region plus one address past its end
    task automatic rd_region(input int r);
        for (int a = 0; a <= depth_of(r); a++) begin
            rd(r, a);
            @(posedge ap_clk); #1;
        end
        rd_idle();
    endtask

    task automatic send_word(input logic [31:0] w);
        bit ok;
        ok = 1'b0;
        s_data = w;
        s_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge ap_clk);
            if (s_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL s_ready_timeout: s_ready stayed 0, expected 1");
        end
        @(posedge ap_clk); #1;
        s_valid = 1'b0;
    endtask

    // Header for region r with count n, then the first nsend payload words
    task automatic pkt(input int r, input int n, input int nsend, input int lock_at, input bit rd_same);
        logic [31:0] w;
        send_word({4'(r), 12'($urandom), 16'(n)});
        if (r <= 4) m_mask[r] = 1'b0;
        if (n == 0 || r > 4) begin
            m_err = 1'b1;
            return;
        end
        for (int i = 0; i < nsend; i++) begin
            w = (r == 4 && i == 0) ? nums_word : $urandom;
            if (i == lock_at) begin
                lock = 1'b1; s_data = w; s_valid = 1'b1;
                for (int c = 0; c < 5; c++) begin
                    rd(r, i);
                    @(negedge ap_clk);
                    chk("s_ready_locked", {31'd0, s_ready}, 32'd0);
                    @(posedge ap_clk); #1;
                end
                rd_idle();
                lock = 1'b0;
            end
            if (rd_same) rd(r, i);
            send_word(w);
            model_write(r, i, w);
        end
        if (rd_same) rd_idle();
        if (nsend == n && n <= depth_of(r)) m_mask[r] = 1'b1;
    endtask

    task automatic chk_flags(input string nm);
        chk({nm, "_mask"}, {27'd0, load_mask}, {27'd0, m_mask});
        chk({nm, "_err"}, {31'd0, load_err}, {31'd0, m_err});
        chk({nm, "_prdy"}, {31'd0, params_ready}, {31'd0, (m_mask == 5'h1F)});
    endtask

    // Monitor: whichever ports were enabled at the last edge must present the next queued value
    initial begin
        logic [4:0] cap;
        forever begin
            @(posedge ap_clk);
            cap = {input_nums_ce0, rule_i_ce0, outMF_i_ce0, inMF_i_ce0, input_data_i_ce0};
            @(negedge ap_clk);
            if (cap[0]) begin if (q_in.size() == 0) miss("rd_in"); else chk("rd_in", input_data_i_q0, q_in.pop_front()); end
            if (cap[1]) begin if (q_mf.size() == 0) miss("rd_inmf"); else chk("rd_inmf", inMF_i_q0, q_mf.pop_front()); end
            if (cap[2]) begin if (q_out.size() == 0) miss("rd_outmf"); else chk("rd_outmf", outMF_i_q0, q_out.pop_front()); end
            if (cap[3]) begin if (q_rule.size() == 0) miss("rd_rule"); else chk("rd_rule", {26'd0, rule_i_q0}, q_rule.pop_front()); end
            if (cap[4]) begin if (q_nums.size() == 0) miss("rd_nums"); else chk("rd_nums", {20'd0, input_nums_q0}, q_nums.pop_front()); end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        nums_word = 32'h0000_0333;
        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk_flags("rst");
        chk("rst_q_in", input_data_i_q0, 32'd0);
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);

        // Full load; region 0 is read at the address being written
        pkt(0, IN_D, IN_D, -1, 1'b1);  chk_flags("load_in");
        pkt(1, MF_D, MF_D, -1, 1'b0);  chk_flags("load_mf");
        pkt(2, OUT_D, OUT_D, -1, 1'b0); chk_flags("load_out");
        pkt(3, RU_D, RU_D, -1, 1'b0);  chk_flags("load_rule");
        pkt(4, 1, 1, -1, 1'b0);        chk_flags("load_nums");
        for (int r = 0; r <= 4; r++) rd_region(r);

        // Oversized rule packet, read while rewriting
        pkt(3, 40, 40, -1, 1'b1);
        chk_flags("rule_over");
        rd_region(3);

        // Idle clear, then a bad header followed by words parsed as headers
        clear = 1'b1; @(posedge ap_clk); #1; clear = 1'b0;
        m_mask = '0; m_err = 1'b0;
        chk_flags("clear_idle");
        pkt(7, 2, 0, -1, 1'b0);
        chk_flags("bad_region");
        pkt(2, 0, 0, -1, 1'b0);
        nums_word = $urandom;
        pkt(4, 1, 1, -1, 1'b0);
        chk_flags("after_bad");
        rd_region(4);

        // Lock mid-payload
        pkt(2, OUT_D, OUT_D, 7, 1'b0);
        chk_flags("lock_pay");
        rd_region(2);

        // Reset mid-packet
        pkt(1, MF_D, 10, -1, 1'b0);
        ap_rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_q_in", input_data_i_q0, 32'd0);
        chk("arst_q_mf", inMF_i_q0, 32'd0);
        chk("arst_q_out", outMF_i_q0, 32'd0);
        chk("arst_q_rule", {26'd0, rule_i_q0}, 32'd0);
        chk("arst_q_nums", {20'd0, input_nums_q0}, 32'd0);
        chk_flags("arst");
        chk("arst_s_ready", {31'd0, s_ready}, 32'd0);
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        pkt(0, IN_D, IN_D, -1, 1'b0);
        chk_flags("post_arst");
        rd_region(1);

        // Clear mid-packet, with a word offered in the same cycle
        pkt(0, IN_D, 1, -1, 1'b0);
        clear = 1'b1; s_data = $urandom; s_valid = 1'b1;
        @(posedge ap_clk); #1;
        clear = 1'b0; s_valid = 1'b0;
        m_mask = '0; m_err = 1'b0;
        chk_flags("clear_mid");
        rd_region(0);
        nums_word = $urandom;
        pkt(4, 1, 1, -1, 1'b0);
        chk_flags("clear_hdr");
        rd_region(4);

        repeat (3) @(posedge ap_clk);
        #1;
        chk("drain", q_in.size() + q_mf.size() + q_out.size() + q_rule.size() + q_nums.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
